fifo_access_ctrl: RTL

// Sequencer and arbiter for the 4-entry shift-register FIFO (3 usable entries; FULL at count 3).

---
 rtl/fifo_access_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: round-robin write / single-consumer read sequencer for a
// 3-usable-entry shift FIFO; one command at a time, always back through IDLE.
module fifo_access_ctrl #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             SYSCLK,
    input  logic             RST_B,
    input  logic             REQ0,
    input  logic [DW-1:0]    DATA0,
    input  logic             REQ1,
    input  logic [DW-1:0]    DATA1,
    output logic             GNT0,
    output logic             GNT1,
    input  logic             RD_REQ,
    output logic [DW-1:0]    OUT_DATA,
    output logic             OUT_VALID,
    output logic             FIFO_WR_EN,
    output logic             FIFO_RD_EN,
    output logic [DW-1:0]    FIFO_IN,
    input  logic [DW-1:0]    FIFO_OUT,
    input  logic             FIFO_EMPTY,
    input  logic             FIFO_FULL,
    output logic [1:0]       LEVEL,
    output logic             LVL_ERR,
    output logic [CNT_W-1:0] WR_TOTAL,
    output logic [CNT_W-1:0] RD_TOTAL
);

    typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;

    state_t state, state_nx;
    logic   rr;
    logic   last_wr;
    logic   wr_ok;
    logic   rd_ok;
    logic   pick1;
    logic   do_wr;
    logic   do_rd;

    assign FIFO_WR_EN = (state == WR);
    assign FIFO_RD_EN = (state == RD);

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) state <= IDLE;
        else        state <= state_nx;
    end

    // Decision only in IDLE; a tie between write and read alternates.
    always_comb begin
        state_nx = state;
        do_wr    = 1'b0;
        do_rd    = 1'b0;
        wr_ok    = (REQ0 | REQ1) & ~FIFO_FULL;
        rd_ok    = RD_REQ & ~FIFO_EMPTY;
        pick1    = REQ1 & (~REQ0 | rr);
        unique case (state)
            IDLE: begin
                if (wr_ok && (!rd_ok || !last_wr)) begin
                    do_wr    = 1'b1;
                    state_nx = WR;
                end else if (rd_ok) begin
                    do_rd    = 1'b1;
                    state_nx = RD;
                end
            end
            WR:      state_nx = IDLE;
            RD:      state_nx = RD_CAP;
            RD_CAP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            rr        <= 1'b0;
            last_wr   <= 1'b0;
            GNT0      <= 1'b0;
            GNT1      <= 1'b0;
            FIFO_IN   <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            LEVEL     <= 2'd0;
            LVL_ERR   <= 1'b0;
            WR_TOTAL  <= '0;
            RD_TOTAL  <= '0;
        end else begin
            GNT0      <= do_wr & ~pick1;
            GNT1      <= do_wr & pick1;
            OUT_VALID <= (state == RD_CAP);
            if (do_wr) begin
                FIFO_IN <= pick1 ? DATA1 : DATA0;
                rr      <= ~pick1;
                last_wr <= 1'b1;
            end
            if (do_rd) last_wr <= 1'b0;
            if (state == WR) begin
                LEVEL    <= LEVEL + 2'd1;
                WR_TOTAL <= WR_TOTAL + 1'b1;
            end
            // FIFO_OUT is only meaningful in the RD_CAP cycle.
            if (state == RD_CAP) begin
                OUT_DATA <= FIFO_OUT;
                LEVEL    <= LEVEL - 2'd1;
                RD_TOTAL <= RD_TOTAL + 1'b1;
            end
            if (state == IDLE &&
                (((LEVEL == 2'd0) != FIFO_EMPTY) ||
                 ((LEVEL == 2'd3) != FIFO_FULL)))
                LVL_ERR <= 1'b1;
        end
    end

endmodule
